// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column strobe, row sampling, frame debounce,
// host-readable key bitmap with sticky press/release events and irq.
module keypad_scan #(
  parameter int SCAN_LIMIT      = 125000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  o_col,
  input  logic [3:0]  i_row,
  input  logic [5:0]  i_addr,
  input  logic        i_oe,
  output logic [15:0] o_data,
  output logic        o_irq
);
  localparam int TW = $clog2(SCAN_LIMIT);
  localparam int SW = $clog2(DEBOUNCE_FRAMES);
  localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_LIMIT - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_FRAMES - 1);

  logic [3:0]    r_row_s1, r_row_s2;
  logic [TW-1:0] r_tick;
  logic [1:0]    r_col;
  logic [3:0]    r_col_drv;
  logic [15:0]   r_frame, r_prev, r_key, r_press, r_rel, r_data;
  logic [SW-1:0] r_stable;
  logic          r_irq;

  logic [3:0]    w_rows_p;
  logic          w_tick_end, w_frame_end, w_match, w_key_upd;
  logic          w_rd_press, w_rd_rel;
  logic [1:0]    w_col_nxt;
  logic [15:0]   w_frame_full, w_press_set, w_rel_set, w_rd_data;
  logic [SW-1:0] w_stable_nxt;

  assign w_rows_p     = ~r_row_s2;
  assign w_tick_end   = (r_tick == TICK_LAST);
  assign w_frame_end  = w_tick_end && (r_col == 2'd3);
  assign w_col_nxt    = r_col + 2'd1;
  // the column-3 slice is still in flight at frame end, so splice it in here
  assign w_frame_full = {w_rows_p, r_frame[11:0]};
  assign w_match      = (w_frame_full == r_prev);

  always_comb begin
    w_stable_nxt = r_stable;
    if (!w_match)
      w_stable_nxt = '0;
    else if (r_stable != STABLE_MAX)
      w_stable_nxt = r_stable + 1'b1;
  end

  assign w_key_upd   = w_frame_end && (w_stable_nxt == STABLE_MAX) && (r_key != w_frame_full);
  assign w_press_set = w_key_upd ? (w_frame_full & ~r_key) : 16'h0000;
  assign w_rel_set   = w_key_upd ? (r_key & ~w_frame_full) : 16'h0000;
  assign w_rd_press  = i_oe && (i_addr == 6'd1);
  assign w_rd_rel    = i_oe && (i_addr == 6'd2);

  always_comb begin
    w_rd_data = 16'h0000;
    if (i_addr[5:2] == 4'd0) begin
      case (i_addr[1:0])
        2'd0:    w_rd_data = r_key;
        2'd1:    w_rd_data = r_press;
        2'd2:    w_rd_data = r_rel;
        default: w_rd_data = {10'b0, 4'(r_stable), r_col};
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_s1  <= 4'hF;
      r_row_s2  <= 4'hF;
      r_tick    <= '0;
      r_col     <= 2'd0;
      r_col_drv <= 4'b1110;
      r_frame   <= 16'h0000;
      r_prev    <= 16'h0000;
      r_stable  <= '0;
      r_key     <= 16'h0000;
      r_press   <= 16'h0000;
      r_rel     <= 16'h0000;
      r_irq     <= 1'b0;
      r_data    <= 16'h0000;
    end else begin
      r_row_s1 <= i_row;
      r_row_s2 <= r_row_s1;
      if (w_tick_end) begin
        r_tick                         <= '0;
        r_frame[{r_col, 2'b00} +: 4]   <= w_rows_p;
        r_col                          <= w_col_nxt;
        r_col_drv                      <= ~(4'b0001 << w_col_nxt);
      end else begin
        r_tick <= r_tick + 1'b1;
      end
      if (w_frame_end) begin
        r_stable <= w_stable_nxt;
        r_prev   <= w_frame_full;
      end
      if (w_key_upd)
        r_key <= w_frame_full;
      // a new event on the clearing edge survives the clear
      r_press <= (w_rd_press ? 16'h0000 : r_press) | w_press_set;
      r_rel   <= (w_rd_rel   ? 16'h0000 : r_rel)   | w_rel_set;
      r_irq   <= (|r_press) | (|r_rel);
      if (i_oe)
        r_data <= w_rd_data;
    end
  end

  assign o_col  = r_col_drv;
  assign o_data = r_data;
  assign o_irq  = r_irq;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a frame-level reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_keypad_scan;
  localparam int SL = 8;
  localparam int DF = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  o_col;
  logic [3:0]  i_row;
  logic [5:0]  i_addr = 6'd0;
  logic        i_oe = 1'b0;
  logic [15:0] o_data;
  logic        o_irq;
  logic        key_down = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  keypad_scan #(.SCAN_LIMIT(SL), .DEBOUNCE_FRAMES(DF)) dut (
    .clk   (clk),
    .rst   (rst),
    .o_col (o_col),
    .i_row (i_row),
    .i_addr(i_addr),
    .i_oe  (i_oe),
    .o_data(o_data),
    .o_irq (o_irq)
  );

  always #5 clk = ~clk;

  // the single modelled key sits at column 1, row 2
  assign i_row = (key_down && !o_col[1]) ? 4'b1011 : 4'hF;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_t = 0;
  int          m_stable = 0;
  logic [3:0]  m_h1 = 4'h0, m_h2 = 4'h0;
  logic [15:0] m_frame = 0, m_prev = 0, m_key = 0, m_press = 0, m_rel = 0, m_data = 0;
  logic        m_irq = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t = 0; m_stable = 0; m_h1 = 0; m_h2 = 0;
      m_frame = 0; m_prev = 0; m_key = 0; m_press = 0; m_rel = 0; m_data = 0;
      m_irq = 1'b0;
    end else begin
      int c;
      logic [3:0]  pr;
      logic [15:0] full, np, nr;
      c  = (m_t / SL) % 4;
      pr = (key_down && c == 1) ? 4'b0100 : 4'b0000;
      np = m_press;
      nr = m_rel;
      m_irq = (m_press != 0) || (m_rel != 0);
      if (i_oe) begin
        case (i_addr)
          6'd0:    m_data = m_key;
          6'd1:    begin m_data = m_press; np = 0; end
          6'd2:    begin m_data = m_rel;   nr = 0; end
          6'd3:    m_data = 16'(m_stable * 4 + c);
          default: m_data = 0;
        endcase
      end
      if (m_t % SL == SL - 1) begin
        m_frame[c*4 +: 4] = m_h2;
        if (c == 3) begin
          full = m_frame;
          m_stable = (full == m_prev) ? ((m_stable + 1 > DF - 1) ? DF - 1 : m_stable + 1) : 0;
          m_prev = full;
          if (m_stable == DF - 1 && m_key != full) begin
            np = np | (full & ~m_key);
            nr = nr | (m_key & ~full);
            m_key = full;
          end
        end
      end
      m_press = np;
      m_rel   = nr;
      m_h2 = m_h1;
      m_h1 = pr;
      m_t++;
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp_col;
    exp_col = ~(4'b0001 << ((m_t / SL) % 4));
    check("cycle", {11'b0, o_col, o_irq, o_data}, {11'b0, exp_col, m_irq, m_data});
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [5:0] a, output logic [15:0] d);
    i_oe = 1'b1; i_addr = a;
    step(1);
    d = o_data;
    i_oe = 1'b0; i_addr = 6'd0;
  endtask

  task automatic poll_key(input logic [15:0] want, input string nm);
    logic [15:0] d;
    d = 16'hxxxx;
    for (int i = 0; i < 130; i++) begin
      rd(6'd0, d);
      if (d == want) break;
    end
    check(nm, d, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    rst = 1'b1;
    step(3);
    rst = 1'b0;

    // 1: idle scan sequence and reset values
    step(1);
    check("t1_col0", o_col, 4'b1110);
    check("t1_irq", o_irq, 1'b0);
    check("t1_data", o_data, 16'h0000);
    step(7);  check("t1_col1", o_col, 4'b1101);
    step(8);  check("t1_col2", o_col, 4'b1011);
    step(8);  check("t1_col3", o_col, 4'b0111);
    step(8);  check("t1_wrap", o_col, 4'b1110);
    rd(6'd0, d); check("t1_key", d, 16'h0000);

    // 2: press and debounce
    key_down = 1'b1;
    poll_key(16'h0040, "t2_key");
    step(1); check("t2_irq_on", o_irq, 1'b1);
    rd(6'd1, d); check("t2_press", d, 16'h0040);
    rd(6'd1, d); check("t2_press_clr", d, 16'h0000);
    step(1); check("t2_irq_off", o_irq, 1'b0);
    step(64);

    // 3: release
    key_down = 1'b0;
    poll_key(16'h0000, "t3_key");
    step(1); check("t3_irq_on", o_irq, 1'b1);
    rd(6'd2, d); check("t3_rel", d, 16'h0040);
    rd(6'd2, d); check("t3_rel_clr", d, 16'h0000);
    step(1); check("t3_irq_off", o_irq, 1'b0);

    // 4: bounce every frame
    for (int f = 0; f < 6; f++) begin
      key_down = (f % 2 == 0);
      for (int k = 0; k < 32; k++) begin
        rd(6'd0, d); check("t4_key", d, 16'h0000);
      end
    end
    key_down = 1'b0;
    step(96);
    rd(6'd1, d); check("t4_press", d, 16'h0000);
    rd(6'd2, d); check("t4_rel", d, 16'h0000);
    check("t4_irq", o_irq, 1'b0);

    // 5: reset mid-dwell on column 2 with the key debounced
    key_down = 1'b1;
    poll_key(16'h0040, "t5_key");
    rd(6'd1, d); check("t5_press", d, 16'h0040);
    for (int i = 0; i < 40; i++) begin
      if (o_col == 4'b1011) break;
      step(1);
    end
    check("t5_on_col2", o_col, 4'b1011);
    step(3);
    rst = 1'b1;
    #1;
    check("t5_rst_col", o_col, 4'b1110);
    check("t5_rst_data", o_data, 16'h0000);
    check("t5_rst_irq", o_irq, 1'b0);
    step(2);
    rst = 1'b0;
    key_down = 1'b0;
    rd(6'd0, d); check("t5_key_after", d, 16'h0000);
    rd(6'd3, d); check("t5_status", d, 16'h0000);
    step(5); check("t5_col_hold", o_col, 4'b1110);
    step(1); check("t5_col_next", o_col, 4'b1101);

    // 6: clear-on-read colliding with a press landing on the same edge
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    key_down = 1'b1;
    step(95);
    rd(6'd1, d); check("t6_old_press", d, 16'h0000);
    step(1); check("t6_irq", o_irq, 1'b1);
    rd(6'd1, d); check("t6_kept_press", d, 16'h0040);
    rd(6'h04, d); check("t6_unmapped", d, 16'h0000);
    rd(6'd0, d); check("t6_key", d, 16'h0040);
    rd(6'd3, d); check("t6_status", d, 16'h0008);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
